// File: rtl/jtframe_rom_arb.sv
// Four-slot ROM read arbiter with a one-word cache per slot in front of the SDRAM read port.
// Define JTFRAME_ROM_RR_EN for round-robin arbitration; default is fixed priority, slot 0 first.
module jtframe_rom_arb #(
  parameter int unsigned AW   = 22,
  parameter int unsigned TOUT = 255
) (
  input  logic            clk_rom,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [3:0]      slot_cs,
  input  logic [4*AW-1:0] slot_addr,
  output logic [4*32-1:0] slot_dout,
  output logic [3:0]      slot_ok,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic [31:0]     data_read,
  input  logic            data_rdy,
  input  logic            loop_rst,
  output logic            refresh_en
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [7:0] TOUT_C = 8'(TOUT);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] fetch_q, fetch_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    ok_q;
  logic [3:0]    cvalid_q;
  logic [AW-1:0] caddr_q [4];
  logic [31:0]   cdata_q [4];

  logic [AW-1:0] addr_arr [4];
  logic [3:0]    hit, miss;
  logic [1:0]    win;
  logic          launch, cwr;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      addr_arr[n] = slot_addr[n*AW +: AW];
      hit[n]      = slot_cs[n] & cvalid_q[n] & (addr_arr[n] == caddr_q[n]);
    end
  end

  assign miss   = slot_cs & ~hit;
  assign launch = (state_q == IDLE) & (|miss) & ~downloading;

`ifdef JTFRAME_ROM_RR_EN
  logic [1:0] ptr_q;

  // Search starts at the slot after the last winner; ptr_q + 0 is tried last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && miss[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (launch) begin
      ptr_q <= win;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (miss[n]) win = 2'(n);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cwr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          gnt_d   = win;
          fetch_d = addr_arr[win];
          addr_d  = addr_arr[win];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (loop_rst) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (sdram_ack) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // loop_rst outranks data_rdy: a restarted controller's data is stale.
        if (loop_rst) begin
          state_d = IDLE;
        end else if (data_rdy) begin
          cwr     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TOUT_C) begin
          req_d   = 1'b1;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (downloading) begin
      state_d = IDLE;
      req_d   = 1'b0;
      cwr     = 1'b0;
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      fetch_q  <= '0;
      gnt_q    <= 2'd0;
      cnt_q    <= 8'd0;
      ok_q     <= 4'd0;
      cvalid_q <= 4'd0;
      for (int n = 0; n < 4; n++) begin
        caddr_q[n] <= '0;
        cdata_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ok_q    <= downloading ? 4'd0 : hit;
      if (downloading) begin
        cvalid_q <= 4'd0;
      end else if (cwr) begin
        // Cache the address that was fetched, not the slot's live address.
        cvalid_q[gnt_q] <= 1'b1;
        caddr_q[gnt_q]  <= fetch_q;
        cdata_q[gnt_q]  <= data_read;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) slot_dout[n*32 +: 32] = cdata_q[n];
  end

  assign slot_ok    = ok_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = downloading | ((state_q == IDLE) & ~(|miss));

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: directed steps plus randomized slot traffic against a cache/memory model.
module tb_jtframe_rom_arb;
  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            rst_n, downloading, loop_rst;
  logic [3:0]      slot_cs, slot_ok;
  logic [4*AW-1:0] slot_addr;
  logic [4*32-1:0] slot_dout;
  logic            sdram_req, sdram_ack, data_rdy, refresh_en;
  logic [AW-1:0]   sdram_addr;
  logic [31:0]     data_read;

  int passed = 0;
  int total  = 0;
  int ack_dly = 1, rdy_dly = 1, rdy_never = 0, n_rdy = 0;

  logic          m_valid [4];
  logic [AW-1:0] m_addr  [4];

  always #5 clk = ~clk;

  jtframe_rom_arb #(.AW(AW), .TOUT(255)) dut (
    .clk_rom    (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_dout  (slot_dout),
    .slot_ok    (slot_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_read  (data_read),
    .data_rdy   (data_rdy),
    .loop_rst   (loop_rst),
    .refresh_en (refresh_en)
  );

  // SDRAM contents: 0x123 holds 0xDEADBEEF, every other address a distinct word.
  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ ((32'(a) - 32'h123) * 32'h9E37_79B1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int n, input logic [AW-1:0] a);
    slot_addr[n*AW +: AW] = a;
  endtask

  function automatic logic [31:0] get_dout(input int n);
    return slot_dout[n*32 +: 32];
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return sdram_req;
      1:       return sdram_ack;
      2:       return data_rdy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int bound, output int cyc);
    cyc = 0;
    while (!sig(which) && cyc < bound) begin
      tick();
      cyc++;
    end
    check(tag, 64'(sig(which)), 64'd1);
  endtask

  task automatic wait_ok(input string tag, input logic [3:0] cs, input int bound);
    int c;
    c = 0;
    while ((slot_ok & cs) != cs && c < bound) begin
      tick();
      c++;
    end
    check(tag, 64'(slot_ok), 64'(cs));
  endtask

  // SDRAM responder: ack ack_dly cycles after seeing a request, data rdy_dly+1 cycles after ack.
  initial begin : sdram_model
    int            ph, cnt;
    logic [AW-1:0] a;
    ph = 0; cnt = 0; a = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      if (!rst_n) begin
        ph = 0;
      end else begin
        if (ph == 0 && sdram_req) begin
          a = sdram_addr; cnt = ack_dly; ph = 1;
        end
        if (ph == 1) begin
          if (cnt == 0) begin
            sdram_ack = 1'b1; cnt = rdy_dly; ph = 2;
          end else cnt--;
        end else if (ph == 2) begin
          if (rdy_never != 0) ph = 0;
          else if (cnt == 0) begin
            data_rdy = 1'b1; data_read = mem(a); n_rdy++; ph = 0;
          end else cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            c;
    logic [AW-1:0] first, second;
    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0; slot_cs = '0; slot_addr = '0;
    for (int n = 0; n < 4; n++) begin m_valid[n] = 1'b0; m_addr[n] = '0; end
    repeat (3) tick();
    check("rst_req", 64'(sdram_req), 64'd0);
    check("rst_addr", 64'(sdram_addr), 64'd0);
    check("rst_ok", 64'(slot_ok), 64'd0);
    check("rst_dout_zero", 64'(slot_dout === 128'd0), 64'd1);
    check("rst_refresh", 64'(refresh_en), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single miss on slot 1
    ack_dly = 2; rdy_dly = 3;
    set_addr(1, 22'h00123); slot_cs = 4'b0010;
    tick();
    check("miss_req", 64'(sdram_req), 64'd1);
    check("miss_addr", 64'(sdram_addr), 64'h123);
    check("miss_refresh_low", 64'(refresh_en), 64'd0);
    wait_for("miss_rdy", 2, 30, c);
    tick();
    check("miss_ok_r1", 64'(slot_ok), 64'd0);
    tick();
    check("miss_ok_r2", 64'(slot_ok), 64'b0010);
    check("miss_dout", 64'(get_dout(1)), 64'hDEADBEEF);
    m_valid[1] = 1'b1; m_addr[1] = 22'h123;
    slot_cs = 4'b0000;
    tick();
    check("hit_ok_drop", 64'(slot_ok), 64'd0);
    slot_cs = 4'b0010;
    tick();
    check("hit_ok", 64'(slot_ok), 64'b0010);
    check("hit_noreq", 64'(sdram_req), 64'd0);

    // Contention between slots 0 and 3, after a slot-0 win
    ack_dly = 1; rdy_dly = 1;
    set_addr(0, 22'h200); slot_cs = 4'b0001;
    wait_ok("c0_pre", 4'b0001, 50);
    m_valid[0] = 1'b1; m_addr[0] = 22'h200;
`ifdef JTFRAME_ROM_RR_EN
    first = 22'h3F3; second = 22'h300;
`else
    first = 22'h300; second = 22'h3F3;
`endif
    set_addr(0, 22'h300); set_addr(3, 22'h3F3); slot_cs = 4'b1001;
    tick();
    check("cont_first", 64'(sdram_addr), 64'(first));
    wait_for("cont_rdy1", 2, 30, c);
    tick();
    wait_for("cont_req2", 0, 30, c);
    check("cont_second", 64'(sdram_addr), 64'(second));
    wait_ok("cont_ok", 4'b1001, 50);
    check("cont_dout0", 64'(get_dout(0)), 64'(mem(22'h300)));
    check("cont_dout3", 64'(get_dout(3)), 64'(mem(22'h3F3)));
    m_valid[0] = 1'b1; m_addr[0] = 22'h300; m_valid[3] = 1'b1; m_addr[3] = 22'h3F3;

    // Slot 2 address moves during WAIT
    ack_dly = 1; rdy_dly = 3;
    set_addr(2, 22'h10); slot_cs = 4'b0100;
    tick();
    wait_for("chg_ack", 1, 30, c);
    tick();
    set_addr(2, 22'h20);
    wait_for("chg_rdy", 2, 30, c);
    tick();
    check("chg_ok_low", 64'(slot_ok), 64'd0);
    set_addr(2, 22'h10);
    tick();
    check("chg_cache_old", 64'(slot_ok), 64'b0100);
    check("chg_old_noreq", 64'(sdram_req), 64'd0);
    set_addr(2, 22'h20);
    tick();
    check("chg_req2", 64'(sdram_req), 64'd1);
    check("chg_addr2", 64'(sdram_addr), 64'h20);
    wait_ok("chg_done", 4'b0100, 50);
    check("chg_dout", 64'(get_dout(2)), 64'(mem(22'h20)));
    m_valid[2] = 1'b1; m_addr[2] = 22'h20;

    // Data never arrives: request re-issued after the timeout
    ack_dly = 1; rdy_dly = 1; rdy_never = 1;
    set_addr(0, 22'h155); slot_cs = 4'b0001;
    tick();
    wait_for("to_ack", 1, 30, c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!sdram_req && c < 400);
    check("to_delay", 64'(c >= 256 && c <= 258), 64'd1);
    check("to_addr", 64'(sdram_addr), 64'h155);
    rdy_never = 0;
    wait_ok("to_done", 4'b0001, 50);
    m_valid[0] = 1'b1; m_addr[0] = 22'h155;

    // loop_rst coincident with data_rdy
    ack_dly = 0; rdy_dly = 2;
    set_addr(1, 22'h77); slot_cs = 4'b0010;
    tick();
    wait_for("lr_rdy", 2, 30, c);
    loop_rst = 1'b1;
    tick();
    loop_rst = 1'b0;
    check("lr_req_low", 64'(sdram_req), 64'd0);
    tick();
    check("lr_reissue", 64'(sdram_req), 64'd1);
    check("lr_addr", 64'(sdram_addr), 64'h77);
    check("lr_nowrite", 64'(slot_ok), 64'd0);
    wait_ok("lr_done", 4'b0010, 50);
    check("lr_dout", 64'(get_dout(1)), 64'(mem(22'h77)));
    m_valid[1] = 1'b1; m_addr[1] = 22'h77;

    // downloading flushes four cached hits
    ack_dly = 1; rdy_dly = 1;
    for (int n = 0; n < 4; n++) set_addr(n, AW'(22'h400 + n));
    slot_cs = 4'b1111;
    wait_ok("dl_fill", 4'b1111, 200);
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    check("dl_ok_drop", 64'(slot_ok), 64'd0);
    check("dl_req_low", 64'(sdram_req), 64'd0);
    tick();
    check("dl_remiss", 64'(sdram_req), 64'd1);
    wait_ok("dl_refill", 4'b1111, 200);
    check("dl_idle_refresh", 64'(refresh_en), 64'd1);
    for (int n = 0; n < 4; n++) begin m_valid[n] = 1'b1; m_addr[n] = AW'(22'h400 + n); end

    // Reset while in REQ
    ack_dly = 8;
    set_addr(2, 22'h555); slot_cs = 4'b0100;
    tick();
    check("rr_req", 64'(sdram_req), 64'd1);
    rst_n = 1'b0;
    tick();
    check("rr_req_low", 64'(sdram_req), 64'd0);
    check("rr_ok", 64'(slot_ok), 64'd0);
    check("rr_dout_zero", 64'(slot_dout === 128'd0), 64'd1);
    rst_n = 1'b1; slot_cs = 4'b0000; ack_dly = 1;
    for (int n = 0; n < 4; n++) m_valid[n] = 1'b0;
    repeat (2) tick();

    // Randomized traffic against the cache model
    for (int it = 0; it < 40; it++) begin
      logic [3:0]    cs;
      int            exp_f, n0;
      logic [AW-1:0] a [4];
      cs = 4'($urandom_range(1, 15));
      ack_dly = $urandom_range(0, 3);
      rdy_dly = $urandom_range(0, 3);
      exp_f = 0;
      for (int n = 0; n < 4; n++) begin
        a[n] = AW'($urandom_range(0, 3) + n * 16);
        set_addr(n, a[n]);
        if (cs[n] && !(m_valid[n] && m_addr[n] == a[n])) exp_f++;
      end
      slot_cs = cs;
      n0 = n_rdy;
      tick();
      wait_ok("rnd_ok", cs, 500);
      check("rnd_fetches", 64'(n_rdy - n0), 64'(exp_f));
      for (int n = 0; n < 4; n++) begin
        if (cs[n]) begin
          check("rnd_dout", 64'(get_dout(n)), 64'(mem(a[n])));
          m_valid[n] = 1'b1;
          m_addr[n]  = a[n];
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtframe_rom_arb.md
# jtframe_rom_arb

Four-slot ROM read arbiter between game-core graphics/sound/CPU ROM fetchers and the frame's single SDRAM read port (`sdram_req`/`sdram_ack`/`data_read`/`data_rdy`/`loop_rst`/`refresh_en`). Each slot keeps a one-word cache so a repeated address is served without SDRAM access. The block grants one miss at a time, tracks the request/ack/ready handshake, and opens refresh windows whenever no request is pending.

## Interface
Parameters:
- `AW`, 22: SDRAM word-address width.
- `TOUT`, 255: cycles to wait for `data_rdy` after `sdram_ack` before re-issuing; 8-bit counter.

Ports:
- `clk_rom`  in  1  ROM/SDRAM clock; everything is clocked on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `downloading`  in  1  ROM download in progress: suspend and flush.
- `slot_cs`  in  4  per-slot read request, level.
- `slot_addr`  in  4*AW  slot *n* at bits [n*AW +: AW].
- `slot_dout`  out  4*32  slot *n* at bits [n*32 +: 32].
- `slot_ok`  out  4  data valid for the current `slot_addr`.
- `sdram_req`  out  1  read request, held until ack.
- `sdram_addr`  out  AW  read address.
- `sdram_ack`  in  1  one-cycle request accept.
- `data_read`  in  32  SDRAM read data.
- `data_rdy`  in  1  one-cycle data-valid strobe.
- `loop_rst`  in  1  controller restart: abort the transaction in flight.
- `refresh_en`  out  1  high when SDRAM refresh is allowed.

## Operation
- Per-slot cache: `cvalid[n]`, `caddr[n]`, `cdata[n]`. Slot *n* hits when `slot_cs[n] & cvalid[n] & slot_addr[n]==caddr[n]`.
- `slot_ok[n]` is registered and equals the hit term from the previous cycle. `slot_dout[n]` equals `cdata[n]`.
- Miss set: `slot_cs[n] & ~hit[n]`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if any miss, pick the winner slot `g`, latch `fetch_addr <= slot_addr[g]` and `sdram_addr <= slot_addr[g]`, set `sdram_req=1`, go to REQ. Otherwise `refresh_en=1`.
  - REQ: hold `sdram_req` and `sdram_addr`. On `sdram_ack`: set `sdram_req=0`, clear the timeout counter, go to WAIT.
  - WAIT: on `data_rdy`: `cdata[g] <= data_read`, `caddr[g] <= fetch_addr`, `cvalid[g] <= 1`, go to IDLE. If the counter reaches TOUT: re-assert `sdram_req` with the same address and go to REQ.
- The cache records the fetched address, not the live one. If `slot_addr[g]` changed mid-fetch, the slot misses afterwards and is fetched again.
- If `slot_cs[g]` drops mid-fetch, the fetch still completes and is cached; `slot_ok[g]` stays 0.
- `loop_rst` in REQ or WAIT: drop `sdram_req`, go to IDLE, no cache write. If `loop_rst` and `data_rdy` arrive in the same cycle, `loop_rst` wins and the data is discarded.
- `downloading=1`: FSM forced to IDLE, `sdram_req=0`, all `cvalid` cleared, `slot_ok=0`, `refresh_en=1`. Takes effect the same edge it is sampled and holds for its whole duration.
- Arbitration defaults to fixed priority, slot 0 highest. See Configuration.

## Timing
- Reset (`rst_n=0` on an edge): state IDLE, `sdram_req=0`, `sdram_addr=0`, `slot_ok=0`, `slot_dout=0`, `cvalid=0`, `refresh_en=1`, timeout counter 0, round-robin pointer 0. Reset mid-transaction abandons the transaction with no cache write.
- Miss path: `slot_cs` rises at cycle 0 → `sdram_req` high at 1. `sdram_ack` at cycle A → `sdram_req` low at A+1. `data_rdy` at cycle R → cache written at R+1 → `slot_ok` high at R+2.
- Hit path: `slot_ok` high one cycle after `slot_cs`/`slot_addr` are presented.
- Address change on a hit slot: `slot_ok` falls one cycle later.
- `refresh_en` is low in REQ and WAIT, and in IDLE during any cycle that has a pending miss.

## Configuration
- `JTFRAME_ROM_RR_EN` defined: round-robin arbitration. A 2-bit pointer searches from the slot after the last winner. The pointer updates when a fetch is launched from IDLE.
- Not defined: fixed priority, lowest index wins. A slot that keeps missing can starve higher-index slots. This is accepted behaviour.

## Test plan
- Single miss: slot 1, addr 0x00123. Model acks after 2 cycles and sends `data_rdy` 4 cycles after ack with 0xDEADBEEF → `sdram_addr`=0x00123, `slot_ok[1]` high 2 cycles after `data_rdy`, `slot_dout[1]`=0xDEADBEEF. Repeat the same address → `slot_ok` after 1 cycle, no new `sdram_req`.
- Contention: slots 0 and 3 miss in the same cycle. Without the macro → slot 0 is fetched first, then slot 3. With `JTFRAME_ROM_RR_EN` after a slot-0 win → slot 3 wins the next contest.
- Address change mid-fetch: slot 2 moves from 0x10 to 0x20 in WAIT → cache holds 0x10, `slot_ok[2]` stays 0, and a second request to 0x20 follows.
- Timeout: no `data_rdy` after ack, TOUT=255 → `sdram_req` re-asserted with the same address.
- `loop_rst` coincident with `data_rdy` → no cache write, state IDLE, and the request is re-issued on the next cycle.
- `downloading` pulse after 4 cached hits → all `slot_ok` drop the next cycle and the same addresses miss afterwards. `rst_n` low during REQ → `sdram_req`=0 on the next edge.
